// File: rtl/mult8_seq_ctrl_pkg.sv
// Shared constants for the nibble-serial 8x8 multiplier controller.
// State encoding, step width and per-step partial-product shifts.
package mult8_seq_ctrl_pkg;

  localparam int STEP_W = 2;
  localparam int NIB_W  = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // lo*lo -> 0, hi*lo -> 4, lo*hi -> 4, hi*hi -> 8
  function automatic logic [3:0] step_shift(
    input logic [STEP_W-1:0] s
  );
    logic [3:0] sh;
    case (s)
      2'd0:    sh = 4'd0;
      2'd1:    sh = 4'd4;
      2'd2:    sh = 4'd4;
      default: sh = 4'd8;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/mult8_seq_ctrl_bitmultiplier.sv
// Combinational 4x4 unsigned array multiplier cell.
// Each set bit of b adds a shifted copy of a into the row sum.
module bitmultiplier
  import mult8_seq_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0]   a,
  input  logic [NIB_W-1:0]   b,
  output logic [2*NIB_W-1:0] p
);

  // sum of shifted partial-product rows
  always_comb begin
    p = '0;
    for (int i = 0; i < NIB_W; i++) begin
      if (b[i]) p = p + ((2*NIB_W)'(a) << i);
    end
  end

endmodule

// File: rtl/mult8_seq_ctrl.sv
// 8x8 unsigned multiplier sequencer around one 4x4 cell.
// Four nibble products are shifted and accumulated, one per cycle.
module mult8_seq_ctrl
  import mult8_seq_ctrl_pkg::*;
#(
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_p,
  output logic        busy
);

  logic [1:0]        state;
  logic [STEP_W-1:0] step;
  logic [7:0]        a_q;
  logic [7:0]        b_q;
  logic [15:0]       acc;
  logic [15:0]       p_q;

  logic [NIB_W-1:0]   a_nib;
  logic [NIB_W-1:0]   b_nib;
  logic [2*NIB_W-1:0] pp;
  logic [15:0]        acc_nx;
  logic               skip;

  // step bit0 picks the high a nibble, bit1 the high b nibble
  assign a_nib = step[0] ? a_q[7:4] : a_q[3:0];
  assign b_nib = step[1] ? b_q[7:4] : b_q[3:0];

  bitmultiplier u_cell (
    .a (a_nib),
    .b (b_nib),
    .p (pp)
  );

  assign acc_nx = acc + (16'(pp) << step_shift(step));

  assign skip = ZERO_SKIP
             && ((in_a == 8'd0) || (in_b == 8'd0));

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign out_p     = p_q;

  // accept, accumulate four partial products, hand off
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      step  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      p_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q  <= in_a;
            b_q  <= in_b;
            acc  <= '0;
            step <= '0;
            if (skip) begin
              p_q   <= '0;
              state <= ST_DONE;
            end else begin
              state <= ST_MUL;
            end
          end
        end
        ST_MUL: begin
          acc  <= acc_nx;
          step <= step + 2'd1;
          if (step == 2'd3) begin
            p_q   <= acc_nx;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Bench for mult8_seq_ctrl: transaction-level model plus directed vectors.
// dut0 has zero skip enabled, dut1 has it disabled; both share inputs.
module tb_mult8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic [1:0]  rdy;
  logic [1:0]  vld;
  logic [1:0]  bsy;
  logic [15:0] p0;
  logic [15:0] p1;

  int nchk = 0;
  int npass = 0;

  always #5 clk = ~clk;

  mult8_seq_ctrl #(.ZERO_SKIP(1'b1)) u_zs (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (rdy[0]),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (vld[0]),
    .out_ready (out_ready),
    .out_p     (p0),
    .busy      (bsy[0])
  );

  mult8_seq_ctrl #(.ZERO_SKIP(1'b0)) u_nz (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (rdy[1]),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (vld[1]),
    .out_ready (out_ready),
    .out_p     (p1),
    .busy      (bsy[1])
  );

  task automatic chk(input string nm, input int k,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s dut%0d got=%h want=%h",
                  nm, k, got, exp);
  endtask

  // Transaction model: one job in flight, product a*b,
  // visible a fixed number of edges after acceptance.
  bit          act[2];
  int          due[2];
  logic [15:0] prod[2];
  logic [15:0] last[2];
  int          ndel[2];
  int          ecnt = 0;
  bit          chk_en = 0;
  bit          zs[2] = '{1'b1, 1'b0};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        act[k]  = 0;
        last[k] = '0;
      end else if (act[k] && ecnt >= due[k]) begin
        if (out_ready) begin
          act[k]  = 0;
          last[k] = prod[k];
          ndel[k]++;
        end
      end else if (!act[k] && in_valid) begin
        act[k]  = 1;
        prod[k] = 16'(in_a) * 16'(in_b);
        due[k]  = ecnt + 1 +
          ((zs[k] && (in_a == 0 || in_b == 0)) ? 0 : 4);
      end
    end
    if (!rst_n) chk_en = 1;
    ecnt++;
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        bit          ev;
        logic [15:0] ep;
        logic [15:0] gp;
        ev = act[k] && (ecnt >= due[k]);
        ep = ev ? prod[k] : last[k];
        gp = (k == 0) ? p0 : p1;
        chk("m_in_ready", k, 32'(rdy[k]), 32'(!act[k]));
        chk("m_out_valid", k, 32'(vld[k]), 32'(ev));
        chk("m_busy", k, 32'(bsy[k]), 32'(act[k]));
        chk("m_out_p", k, 32'(gp), 32'(ep));
      end
    end
  end

  task automatic wait_idle();
    int w;
    w = 0;
    while (bsy != 2'b00 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("idle_wait", 0, 32'(bsy), 32'd0);
  endtask

  // latency counted in edges after the accepting edge
  task automatic run_op(input logic [7:0] a,
                        input logic [7:0] b,
                        input logic [15:0] exp_p,
                        input int lat0,
                        input int lat1);
    int t0;
    int t1;
    t0 = -1;
    t1 = -1;
    wait_idle();
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      if (t0 < 0 && vld[0]) begin
        t0 = c;
        chk("op_p", 0, 32'(p0), 32'(exp_p));
      end
      if (t1 < 0 && vld[1]) begin
        t1 = c;
        chk("op_p", 1, 32'(p1), 32'(exp_p));
      end
      if (t0 >= 0 && t1 >= 0) break;
      @(posedge clk); #1;
    end
    chk("op_lat", 0, 32'(t0), 32'(lat0));
    chk("op_lat", 1, 32'(t1), 32'(lat1));
    wait_idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout dut0 got=running want=done");
    $fatal(1);
  end

  initial begin
    int w;
    bit took;
    int base;
    logic [7:0] ra;
    logic [7:0] rb;

    rst_n = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_in_ready", k, 32'(rdy[k]), 32'd1);
      chk("rst_out_valid", k, 32'(vld[k]), 32'd0);
      chk("rst_busy", k, 32'(bsy[k]), 32'd0);
    end
    chk("rst_out_p", 0, 32'(p0), 32'h0);
    chk("rst_out_p", 1, 32'(p1), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'h12, 8'h34, 16'h03A8, 4, 4);
    run_op(8'hFF, 8'hFF, 16'hFE01, 4, 4);
    run_op(8'h0F, 8'hF0, 16'h0E10, 4, 4);
    run_op(8'h00, 8'hAB, 16'h0000, 0, 4);
    run_op(8'hAB, 8'h00, 16'h0000, 0, 4);
    run_op(8'h01, 8'h01, 16'h0001, 4, 4);

    // output stall with a competing request
    wait_idle();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_a = 8'h12;
    in_b = 8'h34;
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    while (!vld[0] && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("stall_reach", 0, 32'(w), 32'd4);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_a = 8'h55;
      in_b = 8'h66;
      chk("stall_valid", 0, 32'(vld[0]), 32'd1);
      chk("stall_p", 0, 32'(p0), 32'h03A8);
      chk("stall_ready", 0, 32'(rdy[0]), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", 0, 32'(vld[0]), 32'd0);
    chk("stall_hold_p", 0, 32'(p0), 32'h03A8);
    chk("stall_idle", 0, 32'(rdy[0]), 32'd1);

    // reset abandons an operation at step2
    wait_idle();
    in_valid = 1'b1;
    in_a = 8'hAB;
    in_b = 8'hCD;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_valid", 0, 32'(vld[0]), 32'd0);
    chk("abort_busy", 0, 32'(bsy[0]), 32'd0);
    chk("abort_ready", 0, 32'(rdy[0]), 32'd1);
    chk("abort_p", 0, 32'(p0), 32'h0);
    run_op(8'h03, 8'h05, 16'h000F, 4, 4);

    // random back-to-back stream with output stalls
    base = ndel[0];
    for (int i = 0; i < 200; i++) begin
      ra = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      in_valid = 1'b1;
      in_a = ra;
      in_b = rb;
      w = 0;
      took = 0;
      while (!took && w < 200) begin
        out_ready = ($urandom_range(0, 3) != 0);
        took = rdy[0];
        @(posedge clk); #1;
        w++;
      end
      if (!took) chk("stream_accept", 0, 32'd0, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    chk("stream_count", 0, 32'(ndel[0] - base), 32'd200);

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
